// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the 5-stage RV32I pipeline.
//
// Owns the architectural fetch PC. Drives a single-outstanding instruction
// memory port and presents fetched words to IF/ID through a one-entry slot.
// The hazard-unit stall back-pressures that slot. An EX redirect kills the
// slot and flushes IF/ID and ID/EX in the same cycle.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   stall                      ID cannot accept; the slot holds its contents
//   redirect_valid/_pc         EX redirect pulse and target
//   imem_req/_addr             fetch request; addr is stable while req is held
//   imem_rvalid/_rdata         response; may complete in the request cycle
//   if_valid/_pc/_inst         output slot toward IF/ID
//   flush_if_id, flush_id_ex   combinational flush on redirect
//   pc                         next fetch address (debug)
//   misalign_err               sticky: a redirect target was not word aligned
//   imem_timeout               sticky: a request stayed outstanding TIMEOUT cycles
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic [31:0] pc,
  output logic        misalign_err,
  output logic        imem_timeout
);

  localparam int unsigned    CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

  // IDLE: nothing outstanding. BUSY: request outstanding, data wanted.
  // DISCARD: request outstanding but a redirect made its data stale.
  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

  state_t        state, state_n;
  logic [31:0]   pc_n, req_addr, req_addr_n;
  logic          if_valid_n;
  logic [31:0]   if_pc_n, if_inst_n;
  logic          misalign_n, timeout_n;
  logic [CW-1:0] tcnt, tcnt_n;
  logic          slot_free, launch;

  // The slot can take a new word if it is empty or drains at this edge.
  assign slot_free   = !if_valid || !stall;
  assign flush_if_id = redirect_valid && !rst;
  assign flush_id_ex = redirect_valid && !rst;
  assign imem_req    = launch && !rst;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    // Slot drains when ID accepts it; a load below overrides this.
    if_valid_n = if_valid && stall;
    if_pc_n    = if_pc;
    if_inst_n  = if_inst;
    misalign_n = misalign_err;
    tcnt_n     = tcnt;
    launch     = 1'b0;
    imem_addr  = req_addr;

    unique case (state)
      IDLE: begin
        launch    = slot_free && !redirect_valid;
        imem_addr = pc;
        // rvalid without a request here is a stray and is ignored.
        if (launch) begin
          if (imem_rvalid) begin
            if_valid_n = 1'b1;
            if_pc_n    = pc;
            if_inst_n  = imem_rdata;
            pc_n       = pc + 32'd4;
          end else begin
            req_addr_n = pc;
            state_n    = BUSY;
          end
        end
      end
      BUSY: begin
        launch = 1'b1;
        if (imem_rvalid) begin
          state_n = IDLE;
          if (!redirect_valid) begin
            // Launch required slot_free, so the slot is empty here.
            if_valid_n = 1'b1;
            if_pc_n    = req_addr;
            if_inst_n  = imem_rdata;
            pc_n       = req_addr + 32'd4;
          end
        end else if (redirect_valid) begin
          state_n = DISCARD;
        end
      end
      DISCARD: begin
        launch = 1'b1;
        if (imem_rvalid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Redirect wins over stall and over any response.
    if (redirect_valid) begin
      pc_n       = {redirect_pc[31:2], 2'b00};
      if_valid_n = 1'b0;
      if (redirect_pc[1:0] != 2'b00) misalign_n = 1'b1;
    end

    if (state_n == IDLE || imem_rvalid)
      tcnt_n = '0;
    else if (state != IDLE && tcnt != TMAX)
      tcnt_n = tcnt + 1'b1;

    timeout_n = imem_timeout || (tcnt_n == TMAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_inst      <= '0;
      misalign_err <= 1'b0;
      imem_timeout <= 1'b0;
      tcnt         <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      req_addr     <= req_addr_n;
      if_valid     <= if_valid_n;
      if_pc        <= if_pc_n;
      if_inst      <= if_inst_n;
      misalign_err <= misalign_n;
      imem_timeout <= timeout_n;
      tcnt         <= tcnt_n;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl. A small memory responder answers requests after a
// programmable latency (or never, while hold is set). Expected slot words are
// queued by the stimulus; a negedge monitor pops one each time ID accepts the
// slot. Data words are 0xABC0_0000 | address.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] pc;
  logic        misalign_err;
  logic        imem_timeout;

  logic [3:0]  lat;
  logic        hold;
  logic [3:0]  mem_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0), .TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .pc             (pc),
    .misalign_err   (misalign_err),
    .imem_timeout   (imem_timeout)
  );

  // Memory responder: answers when the request has been held 'lat' cycles.
  assign imem_rvalid = imem_req && !hold && (mem_cnt == lat);
  assign imem_rdata  = imem_rvalid ? (32'hABC0_0000 | imem_addr) : 32'h0;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_rvalid) mem_cnt <= 4'd0;
    else                                 mem_cnt <= mem_cnt + 4'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    sb.push_back({p, i});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a slot word is delivered when valid, not stalled, not flushed.
  always @(negedge clk) begin
    if (!rst && if_valid && !stall && !redirect_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc %h inst %h expected nothing", if_pc, if_inst);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (if_pc !== e.pc || if_inst !== e.inst) begin
          errors++;
          $display("FAIL sb_slot: got pc %h inst %h expected pc %h inst %h",
                   if_pc, if_inst, e.pc, e.inst);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    lat = 4'd0; hold = 1'b0;
    cyc(); cyc();
    // Flush must be masked while in reset.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_flush_if_id", flush_if_id, 0);
    chk("rst_flush_id_ex", flush_id_ex, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_misalign", misalign_err, 0);
    chk("rst_timeout", imem_timeout, 0);

    // Zero-wait streaming.
    cyc(); rst = 1'b0; redirect_valid = 1'b0;
    push(32'h0, 32'hABC0_0000);
    push(32'h4, 32'hABC0_0004);
    push(32'h8, 32'hABC0_0008);
    push(32'hC, 32'hABC0_000C);
    #2;
    chk("z_req0", imem_req, 1);
    chk("z_addr0", imem_addr, 32'h0);
    chk("z_flush", flush_if_id, 0);
    cyc(); #2;
    chk("z_addr4", imem_addr, 32'h4);
    chk("z_ifpc0", if_pc, 32'h0);
    cyc(); #2;
    chk("z_addr8", imem_addr, 32'h8);
    chk("z_ifpc4", if_pc, 32'h4);

    // Stall 5 cycles with 0x8 in the slot; latency becomes 3.
    cyc(); stall = 1'b1; lat = 4'd3;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("st_req", imem_req, 0);
      chk("st_ifpc", if_pc, 32'h8);
      chk("st_inst", if_inst, 32'hABC0_0008);
      if (i < 4) cyc();
    end
    cyc(); stall = 1'b0;
    #2;
    chk("st_launch_req", imem_req, 1);
    chk("st_launch_addr", imem_addr, 32'hC);
    cyc(); #2;
    chk("busy_addr_a", imem_addr, 32'hC);
    cyc(); #2;
    chk("busy_addr_b", imem_addr, 32'hC);
    cyc();
    cyc(); #2;
    chk("lat_ifpc", if_pc, 32'hC);
    chk("lat_gap_addr", imem_addr, 32'h10);

    // Redirect while BUSY on 0x10 -> DISCARD.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100;
    #2;
    chk("rd_flush_if_id", flush_if_id, 1);
    chk("rd_flush_id_ex", flush_id_ex, 1);
    chk("rd_addr", imem_addr, 32'h10);
    cyc(); redirect_valid = 1'b0;
    #2;
    chk("rd_flush_off", flush_if_id, 0);
    chk("rd_pc", pc, 32'h100);
    chk("disc_req", imem_req, 1);
    chk("disc_addr", imem_addr, 32'h10);
    cyc(); #2;
    chk("disc_addr2", imem_addr, 32'h10);
    cyc(); #2;
    chk("disc_drop", if_valid, 0);
    chk("disc_next_req", imem_req, 1);
    chk("disc_next_addr", imem_addr, 32'h100);

    // Redirect to 0x200 coincident with rvalid for 0x100, under stall.
    cyc(); stall = 1'b1;
    #2;
    chk("stall_busy_addr", imem_addr, 32'h100);
    cyc();
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    #2;
    chk("co_flush", flush_if_id, 1);
    cyc(); redirect_valid = 1'b0;
    #2;
    chk("co_drop", if_valid, 0);
    chk("co_req", imem_req, 1);
    chk("co_addr", imem_addr, 32'h200);

    // 0x200 lands in the slot; misaligned redirect kills it under stall.
    cyc(); cyc(); cyc();
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h103;
    #2;
    chk("ma_slot_valid", if_valid, 1);
    chk("ma_slot_pc", if_pc, 32'h200);
    chk("ma_req_blocked", imem_req, 0);
    chk("ma_flush", flush_id_ex, 1);
    cyc(); redirect_valid = 1'b0; stall = 1'b0; lat = 4'd0;
    push(32'h100, 32'hABC0_0100);
    push(32'h104, 32'hABC0_0104);
    push(32'h108, 32'hABC0_0108);
    #2;
    chk("ma_pc", pc, 32'h100);
    chk("ma_err", misalign_err, 1);
    chk("ma_killed", if_valid, 0);
    chk("ma_addr", imem_addr, 32'h100);
    cyc(); #2;
    chk("ma_ifpc", if_pc, 32'h100);
    cyc();

    // Withhold the response for 0x10C to trip the timeout.
    cyc(); hold = 1'b1;
    #2;
    chk("to_req", imem_req, 1);
    chk("to_addr", imem_addr, 32'h10C);
    chk("ma_sticky", misalign_err, 1);
    cyc(); cyc();
    cyc(); #2;
    chk("to_early", imem_timeout, 0);
    chk("to_addr_held", imem_addr, 32'h10C);
    cyc(); cyc();
    cyc(); #2;
    chk("to_raised", imem_timeout, 1);
    chk("to_ma_sticky", misalign_err, 1);

    // Reset in the middle of the outstanding request.
    cyc(); rst = 1'b1;
    #2;
    chk("mr_req_in_rst", imem_req, 0);
    cyc(); hold = 1'b0;
    #2;
    chk("mr_pc", pc, 32'h0);
    chk("mr_timeout", imem_timeout, 0);
    chk("mr_misalign", misalign_err, 0);
    chk("mr_if_valid", if_valid, 0);
    chk("mr_req", imem_req, 0);
    cyc(); rst = 1'b0;
    push(32'h0, 32'hABC0_0000);
    #2;
    chk("mr_restart_req", imem_req, 1);
    chk("mr_restart_addr", imem_addr, 32'h0);
    cyc();
    cyc(); stall = 1'b1;
    cyc(); cyc();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
